// File: rtl/usb_data_buffer.sv
// ---------------------------------------------------------------------------
// usb_data_buffer
//
// Purpose:
//   64-byte, byte-wide FIFO between the USB RX/TX packet engines and the
//   AHB-Lite slave. The RX engine pushes one byte per strobe and the AHB
//   slave pops 1-4 bytes per read. The AHB slave pushes 1-4 bytes per write
//   and the TX engine pops one byte per strobe.
//
// Ports:
//   clk                   system clock, rising-edge
//   n_rst                 asynchronous active-high reset (legacy name)
//   clear                 synchronous flush of the buffer
//   store_rx_packet_data  push rx_packet_data (ignored while buffer_reserved)
//   rx_packet_data[7:0]   byte from USB RX engine
//   get_rx_data           pop data_size+1 bytes into rx_data
//   data_size[1:0]        transfer size minus one for AHB push/pop
//   tx_data[31:0]         AHB write data, byte 0 in [7:0]
//   store_tx_data         push data_size+1 bytes of tx_data
//   get_tx_packet_data    pop one byte into tx_packet_data
//   buffer_reserved       buffer owned by the TX path
//   buffer_occupancy[6:0] bytes stored, 0..64
//   rx_data[31:0]         last AHB read word, zero-extended
//   tx_packet_data[7:0]   last byte popped by the TX engine
//
// Optional feature (macro DATA_BUFFER_STATUS_EN):
//   overflow / underflow  sticky flags for dropped pushes and short pops,
//                         cleared by n_rst or clear
// ---------------------------------------------------------------------------
module usb_data_buffer (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        store_rx_packet_data,
    input  logic [7:0]  rx_packet_data,
    input  logic        get_rx_data,
    input  logic [1:0]  data_size,
    input  logic [31:0] tx_data,
    input  logic        store_tx_data,
    input  logic        get_tx_packet_data,
    input  logic        buffer_reserved,
`ifdef DATA_BUFFER_STATUS_EN
    output logic        overflow,
    output logic        underflow,
`endif
    output logic [6:0]  buffer_occupancy,
    output logic [31:0] rx_data,
    output logic [7:0]  tx_packet_data
);

    logic [7:0] mem [0:63];
    logic [5:0] wptr;
    logic [5:0] rptr;

    logic [2:0]  push_req;
    logic [2:0]  pop_req;
    logic [2:0]  push_cnt;
    logic [2:0]  pop_cnt;
    logic [6:0]  free_space;
    logic        push_drop;
    logic        pop_short;
    logic [7:0]  push_byte [0:3];
    logic [31:0] pop_word;

    // Resolve this cycle's push and pop requests. The AHB side wins over the
    // packet engine on each direction. Both limits use the pre-update
    // occupancy, so a same-cycle pop never sees the byte being pushed and a
    // same-cycle push never uses the slot being freed.
    always_comb begin
        push_req = 3'd0;
        pop_req  = 3'd0;
        if (store_tx_data)
            push_req = {1'b0, data_size} + 3'd1;
        else if (store_rx_packet_data && !buffer_reserved)
            push_req = 3'd1;
        if (get_rx_data)
            pop_req = {1'b0, data_size} + 3'd1;
        else if (get_tx_packet_data)
            pop_req = 3'd1;

        free_space = 7'd64 - buffer_occupancy;
        // When the request exceeds what is available, the available count is
        // below 4 and fits in three bits.
        push_cnt  = ({4'd0, push_req} > free_space)       ? free_space[2:0]       : push_req;
        pop_cnt   = ({4'd0, pop_req}  > buffer_occupancy) ? buffer_occupancy[2:0] : pop_req;
        push_drop = (push_req != push_cnt);
        pop_short = (pop_req != pop_cnt);

        // Bytes that are not present read back as zero.
        pop_word = 32'd0;
        for (int i = 0; i < 4; i++) begin
            push_byte[i] = store_tx_data ? tx_data[8*i +: 8] : rx_packet_data;
            if (3'(i) < pop_cnt)
                pop_word[8*i +: 8] = mem[rptr + 6'(i)];
        end
    end

    // Storage array carries no reset; its contents are meaningless once the
    // pointers are cleared.
    always_ff @(posedge clk) begin
        if (!n_rst && !clear) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < push_cnt)
                    mem[wptr + 6'(i)] <= push_byte[i];
            end
        end
    end

    // Pointers, occupancy and output registers. clear empties the buffer but
    // leaves the last popped values visible.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            wptr             <= 6'd0;
            rptr             <= 6'd0;
            buffer_occupancy <= 7'd0;
            rx_data          <= 32'd0;
            tx_packet_data   <= 8'd0;
        end else if (clear) begin
            wptr             <= 6'd0;
            rptr             <= 6'd0;
            buffer_occupancy <= 7'd0;
        end else begin
            wptr             <= wptr + {3'd0, push_cnt};
            rptr             <= rptr + {3'd0, pop_cnt};
            buffer_occupancy <= buffer_occupancy + {4'd0, push_cnt} - {4'd0, pop_cnt};
            if (get_rx_data)
                rx_data <= pop_word;
            else if (get_tx_packet_data && (pop_cnt != 3'd0))
                tx_packet_data <= pop_word[7:0];
        end
    end

`ifdef DATA_BUFFER_STATUS_EN
    // Sticky error flags: once set they stay until reset or flush.
    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_drop)
                overflow <= 1'b1;
            if (pop_short)
                underflow <= 1'b1;
        end
    end
`else
    logic unused_status;
    assign unused_status = push_drop ^ pop_short;
`endif

endmodule

// File: tb/tb_usb_data_buffer.sv
// ---------------------------------------------------------------------------
// tb_usb_data_buffer
//
// Directed, self-checking bench for usb_data_buffer. Every expected value is
// a hand-computed constant. Optional status flags are checked only when
// DATA_BUFFER_STATUS_EN is defined.
// ---------------------------------------------------------------------------
module tb_usb_data_buffer;

    logic        tb_clk;
    logic        n_rst;
    logic        clear;
    logic        store_rx_packet_data;
    logic [7:0]  rx_packet_data;
    logic        get_rx_data;
    logic [1:0]  data_size;
    logic [31:0] tx_data;
    logic        store_tx_data;
    logic        get_tx_packet_data;
    logic        buffer_reserved;
    logic [6:0]  buffer_occupancy;
    logic [31:0] rx_data;
    logic [7:0]  tx_packet_data;
`ifdef DATA_BUFFER_STATUS_EN
    logic        overflow;
    logic        underflow;
`endif

    int checks = 0;
    int errors = 0;

    usb_data_buffer dut (
        .clk                  (tb_clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_rx_data          (get_rx_data),
        .data_size            (data_size),
        .tx_data              (tx_data),
        .store_tx_data        (store_tx_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .buffer_reserved      (buffer_reserved),
`ifdef DATA_BUFFER_STATUS_EN
        .overflow             (overflow),
        .underflow            (underflow),
`endif
        .buffer_occupancy     (buffer_occupancy),
        .rx_data              (rx_data),
        .tx_packet_data       (tx_packet_data)
    );

    // 10 ns clock; inputs change and outputs are sampled 1 ns after each
    // rising edge.
    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    task automatic clearStrobes();
        store_rx_packet_data = 1'b0;
        get_rx_data          = 1'b0;
        store_tx_data        = 1'b0;
        get_tx_packet_data   = 1'b0;
        clear                = 1'b0;
    endtask

    // Hold the given strobes across one rising edge, then drop them.
    task automatic applyStimulus(input logic srx, input logic [7:0] rxd,
                                 input logic grx, input logic [1:0] ds,
                                 input logic stx, input logic [31:0] txd,
                                 input logic gtx);
        store_rx_packet_data = srx;
        rx_packet_data       = rxd;
        get_rx_data          = grx;
        data_size            = ds;
        store_tx_data        = stx;
        tx_data              = txd;
        get_tx_packet_data   = gtx;
        @(posedge tb_clk);
        #1;
        clearStrobes();
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic pulseReset();
        n_rst = 1'b1;
        @(posedge tb_clk);
        #1;
        n_rst = 1'b0;
    endtask

    initial begin
        n_rst           = 1'b1;
        buffer_reserved = 1'b0;
        rx_packet_data  = 8'h00;
        data_size       = 2'd0;
        tx_data         = 32'd0;
        clearStrobes();

        // Reset state
        @(posedge tb_clk);
        #1;
        checkOutput("reset_occ", 32'(buffer_occupancy), 32'd0);
        checkOutput("reset_rx",  rx_data, 32'd0);
        checkOutput("reset_tx",  32'(tx_packet_data), 32'd0);
`ifdef DATA_BUFFER_STATUS_EN
        checkOutput("reset_ovf", 32'(overflow), 32'd0);
        checkOutput("reset_unf", 32'(underflow), 32'd0);
`endif
        n_rst = 1'b0;

        // RX pushes, then one 4-byte AHB read
        $display("[TB] RX push and 4-byte read");
        applyStimulus(1, 8'h11, 0, 2'd0, 0, 32'd0, 0);
        applyStimulus(1, 8'h22, 0, 2'd0, 0, 32'd0, 0);
        applyStimulus(1, 8'h33, 0, 2'd0, 0, 32'd0, 0);
        applyStimulus(1, 8'h44, 0, 2'd0, 0, 32'd0, 0);
        checkOutput("rxpush_occ", 32'(buffer_occupancy), 32'd4);
        applyStimulus(0, 8'h00, 1, 2'd3, 0, 32'd0, 0);
        checkOutput("rxread_data", rx_data, 32'h44332211);
        checkOutput("rxread_occ",  32'(buffer_occupancy), 32'd0);

        // AHB 2-byte write, two TX pops, then a pop on empty
        $display("[TB] AHB write and TX pops");
        pulseReset();
        applyStimulus(0, 8'h00, 0, 2'd1, 1, 32'h0000BEEF, 0);
        checkOutput("txpush_occ", 32'(buffer_occupancy), 32'd2);
        applyStimulus(0, 8'h00, 0, 2'd0, 0, 32'd0, 1);
        checkOutput("txpop1_data", 32'(tx_packet_data), 32'h000000EF);
        checkOutput("txpop1_occ",  32'(buffer_occupancy), 32'd1);
        applyStimulus(0, 8'h00, 0, 2'd0, 0, 32'd0, 1);
        checkOutput("txpop2_data", 32'(tx_packet_data), 32'h000000BE);
        checkOutput("txpop2_occ",  32'(buffer_occupancy), 32'd0);
        applyStimulus(0, 8'h00, 0, 2'd0, 0, 32'd0, 1);
        checkOutput("txpop_empty_data", 32'(tx_packet_data), 32'h000000BE);
        checkOutput("txpop_empty_occ",  32'(buffer_occupancy), 32'd0);
`ifdef DATA_BUFFER_STATUS_EN
        checkOutput("txpop_empty_unf", 32'(underflow), 32'd1);
`endif

        // Fill to 64, overflow push, then drain with 16 word reads
        $display("[TB] fill, overflow and wrap");
        pulseReset();
        for (int i = 0; i < 64; i++)
            applyStimulus(1, 8'(i), 0, 2'd0, 0, 32'd0, 0);
        checkOutput("full_occ", 32'(buffer_occupancy), 32'd64);
        applyStimulus(1, 8'hFF, 0, 2'd0, 0, 32'd0, 0);
        checkOutput("overfill_occ", 32'(buffer_occupancy), 32'd64);
        applyStimulus(0, 8'h00, 0, 2'd3, 1, 32'hDDCCBBAA, 0);
        checkOutput("overfill_tx_occ", 32'(buffer_occupancy), 32'd64);
`ifdef DATA_BUFFER_STATUS_EN
        checkOutput("overfill_ovf", 32'(overflow), 32'd1);
        checkOutput("overfill_unf", 32'(underflow), 32'd0);
`endif
        for (int k = 0; k < 16; k++) begin
            applyStimulus(0, 8'h00, 1, 2'd3, 0, 32'd0, 0);
            checkOutput($sformatf("drain_word%0d", k), rx_data,
                        32'h03020100 + 32'h04040404 * 32'(k));
        end
        checkOutput("drain_occ", 32'(buffer_occupancy), 32'd0);
        // Pointers have wrapped to slot 0; the buffer still works
        applyStimulus(0, 8'h00, 0, 2'd2, 1, 32'h00C0B0A0, 0);
        applyStimulus(0, 8'h00, 1, 2'd2, 0, 32'd0, 0);
        checkOutput("wrap_word", rx_data, 32'h00C0B0A0);

        // Short read
        $display("[TB] short read");
        pulseReset();
        applyStimulus(1, 8'hAA, 0, 2'd0, 0, 32'd0, 0);
        applyStimulus(1, 8'hBB, 0, 2'd0, 0, 32'd0, 0);
        applyStimulus(0, 8'h00, 1, 2'd3, 0, 32'd0, 0);
        checkOutput("short_data", rx_data, 32'h0000BBAA);
        checkOutput("short_occ",  32'(buffer_occupancy), 32'd0);
`ifdef DATA_BUFFER_STATUS_EN
        checkOutput("short_unf", 32'(underflow), 32'd1);
`endif

        // Reserved buffer and same-cycle push/pop
        $display("[TB] reserved and same-cycle push/pop");
        buffer_reserved = 1'b1;
        applyStimulus(1, 8'h55, 0, 2'd0, 0, 32'd0, 0);
        checkOutput("reserved_occ", 32'(buffer_occupancy), 32'd0);
        applyStimulus(0, 8'h00, 0, 2'd0, 1, 32'h00000077, 0);
        checkOutput("reserved_txpush_occ", 32'(buffer_occupancy), 32'd1);
        applyStimulus(0, 8'h00, 0, 2'd0, 1, 32'h00000088, 1);
        checkOutput("samecyc_occ",  32'(buffer_occupancy), 32'd1);
        checkOutput("samecyc_data", 32'(tx_packet_data), 32'h00000077);
        applyStimulus(0, 8'h00, 0, 2'd0, 0, 32'd0, 1);
        checkOutput("samecyc_next", 32'(tx_packet_data), 32'h00000088);
        buffer_reserved = 1'b0;

        // Push and pop priority
        $display("[TB] source priority");
        applyStimulus(1, 8'h12, 0, 2'd0, 1, 32'h00000099, 0);
        checkOutput("pushprio_occ", 32'(buffer_occupancy), 32'd1);
        applyStimulus(0, 8'h00, 0, 2'd0, 0, 32'd0, 1);
        checkOutput("pushprio_data", 32'(tx_packet_data), 32'h00000099);
        applyStimulus(0, 8'h00, 0, 2'd1, 1, 32'h00002211, 0);
        applyStimulus(0, 8'h00, 1, 2'd0, 0, 32'd0, 1);
        checkOutput("popprio_rx",  rx_data, 32'h00000011);
        checkOutput("popprio_tx",  32'(tx_packet_data), 32'h00000099);
        checkOutput("popprio_occ", 32'(buffer_occupancy), 32'd1);

        // clear flushes but keeps output registers
        $display("[TB] clear and mid-stream reset");
        applyStimulus(0, 8'h00, 0, 2'd3, 1, 32'h04030201, 0);
        applyStimulus(0, 8'h00, 0, 2'd3, 1, 32'h08070605, 0);
        applyStimulus(0, 8'h00, 0, 2'd1, 1, 32'h00000A09, 0);
        checkOutput("load10_occ", 32'(buffer_occupancy), 32'd11);
        clear = 1'b1;
        @(posedge tb_clk);
        #1;
        clear = 1'b0;
        checkOutput("clear_occ", 32'(buffer_occupancy), 32'd0);
        checkOutput("clear_rx",  rx_data, 32'h00000011);
        checkOutput("clear_tx",  32'(tx_packet_data), 32'h00000099);
`ifdef DATA_BUFFER_STATUS_EN
        checkOutput("clear_ovf", 32'(overflow), 32'd0);
        checkOutput("clear_unf", 32'(underflow), 32'd0);
`endif
        applyStimulus(0, 8'h00, 0, 2'd1, 1, 32'h0000C3B2, 0);
        applyStimulus(0, 8'h00, 1, 2'd1, 0, 32'd0, 0);
        checkOutput("postclear_rx", rx_data, 32'h0000C3B2);

        // Asynchronous reset in the middle of a push stream
        applyStimulus(1, 8'h5A, 0, 2'd0, 0, 32'd0, 0);
        store_rx_packet_data = 1'b1;
        rx_packet_data       = 8'h5B;
        #2;
        n_rst = 1'b1;
        #1;
        checkOutput("asyncrst_occ", 32'(buffer_occupancy), 32'd0);
        checkOutput("asyncrst_rx",  rx_data, 32'd0);
        checkOutput("asyncrst_tx",  32'(tx_packet_data), 32'd0);
        n_rst = 1'b0;
        clearStrobes();
        @(posedge tb_clk);
        #1;
        checkOutput("afterrst_occ", 32'(buffer_occupancy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/usb_data_buffer.md
# usb_data_buffer

64-byte byte-wide FIFO shared between the USB RX/TX packet engines and the AHB-Lite slave. The RX engine pushes received bytes one at a time and the AHB slave pops 1–4 bytes per read. The AHB slave pushes 1–4 bytes per write and the TX engine pops them one at a time. Sits between the USB protocol controllers and the AHB-Lite slave register file.

## Interface
Parameters: none. Depth fixed at 64 bytes.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- n_rst  in  1  reset. Asynchronous and active-high: asserted at 1, which empties the buffer and zeroes all outputs. The name is kept for codebase compatibility.
- clear  in  1  synchronous flush: empties the buffer
- store_rx_packet_data  in  1  push rx_packet_data this cycle
- rx_packet_data  in  8  byte from USB RX
- get_rx_data  in  1  pop data_size+1 bytes to rx_data
- data_size  in  2  transfer size minus one (0=1 byte … 3=4 bytes); shared by get_rx_data and store_tx_data
- tx_data  in  32  AHB write data; byte 0 in [7:0]
- store_tx_data  in  1  push data_size+1 bytes of tx_data
- get_tx_packet_data  in  1  pop one byte to tx_packet_data
- buffer_reserved  in  1  buffer owned by the TX path; RX pushes are ignored while it is high
- buffer_occupancy  out  7  bytes stored, 0..64
- rx_data  out  32  last popped AHB read word, zero-extended
- tx_packet_data  out  8  last popped TX byte

## Operation
- Storage: 64×8 array with 6-bit read and write pointers that wrap modulo 64. Occupancy counts 0..64.
- RX push: when store_rx_packet_data=1 and buffer_reserved=0 and occupancy<64, write rx_packet_data at wptr.
- TX push: when store_tx_data=1, write bytes tx_data[7:0], [15:8], … in that order, N=data_size+1 bytes in total. Bytes are accepted only up to the free space; excess bytes are dropped.
- RX pop: when get_rx_data=1, pop N=data_size+1 bytes in FIFO order.
  - rx_data = {0…, byte[N-1], …, byte1, byte0}; the oldest byte goes to [7:0].
  - If occupancy<N, pop only what is present; missing bytes read as 0.
- TX pop: when get_tx_packet_data=1 and occupancy>0, tx_packet_data ← oldest byte. When empty, tx_packet_data holds its value and occupancy stays 0.
- Both output registers hold their values until the next pop.
- Priority: n_rst > clear > data operations.
  - clear zeroes the pointers and occupancy; rx_data and tx_packet_data hold.
- Same-cycle push and pop are both performed.
  - The pop limit uses occupancy before the push.
  - The push limit uses free space before the pop.
  - New occupancy = old + accepted pushes − actual pops.
- Multiple push sources in one cycle: store_tx_data wins and the RX push is dropped. Multiple pops in one cycle: get_rx_data wins.

## Timing
- Reset values: buffer_occupancy=0, rx_data=0, tx_packet_data=0, pointers 0.
- Strobes are sampled at the rising edge. rx_data, tx_packet_data and buffer_occupancy are registered and update at that same edge, so they are valid one cycle after the strobe is driven.
- One operation per strobe-high cycle. A strobe held high for k cycles performs k operations.
- Reset mid-operation aborts the transfer immediately; contents are lost.
- Full throughput: one push and one pop per cycle, sustained.

## Configuration
- DATA_BUFFER_STATUS_EN defined: adds outputs overflow (1b) and underflow (1b).
  - Sticky flags set when a push drops bytes or a pop finds too few bytes.
  - Cleared by n_rst or clear.
- Not defined: these ports and their logic are absent; drop and underflow behaviour is otherwise identical.

## Test plan
- Reset, then RX push of 0x11,0x22,0x33,0x44 → occupancy=4. get_rx_data with data_size=3 → rx_data=0x44332211, occupancy=0.
- Reset, then store_tx_data with data_size=1, tx_data=0x0000BEEF → occupancy=2. Two get_tx_packet_data pulses → 0xEF then 0xBE, occupancy=0.
- 64 RX pushes of incrementing bytes 0x00..0x3F → occupancy=64. A 65th push is ignored (overflow=1 if enabled). 16 reads with data_size=3 return 0x03020100 … 0x3F3E3D3C, exercising pointer wrap.
- Push 2 bytes 0xAA,0xBB, then get_rx_data with data_size=3 → rx_data=0x0000BBAA, occupancy=0 (underflow=1 if enabled).
- With buffer_reserved=1, RX push of 0x55 → occupancy unchanged. Same-cycle TX push of 1 byte and TX pop at occupancy=1 → occupancy stays 1 and tx_packet_data is the older byte.
- Load 10 bytes, then pulse clear → occupancy=0. Assert n_rst mid-stream → all outputs read 0.
